// File: rtl/clk_switch_pkg.sv
// Shared types for the clock-switch scheduler: select encodings and FSM states.
package clk_switch_pkg;

  typedef enum logic [1:0] {
    FAST    = 2'b00,
    SLOW    = 2'b01,
    NOMINAL = 2'b10
  } clk_sel_t;

  typedef enum logic [1:0] {
    IDLE,
    QUIESCE,
    ISSUE,
    SETTLE
  } sched_state_t;

  localparam clk_sel_t CLK_SEL_RESET = NOMINAL;

  // The unused encoding 2'b11 is folded onto NOMINAL.
  function automatic clk_sel_t normalize_sel(input logic [1:0] raw);
    return (raw == 2'b11) ? NOMINAL : clk_sel_t'(raw);
  endfunction

endpackage

// File: rtl/clk_switch_sched_arb.sv
// Round-robin arbiter: one-hot grant to the first request at or after ptr,
// wrapping past the top index.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 16,
  parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic        found;
  int unsigned idx;

  // Scan from the priority pointer; the first asserted request wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_switch_sched.sv
// Per-tile clock-select change scheduler: arbitrates requests, stalls the
// target tile, drives its switcher handshake, then holds a settle window.
// Optional macro CLK_SWITCH_SCHED_PERF_EN adds a saturating switch_count output.
module clk_switch_sched
  import clk_switch_pkg::*;
#(
  parameter int unsigned NUM_TILES      = 16,
  parameter int unsigned QUIESCE_CYCLES = 2,
  parameter int unsigned SETTLE_CYCLES  = 4
) (
`ifdef CLK_SWITCH_SCHED_PERF_EN
  output logic [15:0]            switch_count,
`endif
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_TILES-1:0]   req_val,
  output logic [NUM_TILES-1:0]   req_rdy,
  input  logic [2*NUM_TILES-1:0] req_msg,
  output logic [NUM_TILES-1:0]   sw_val,
  input  logic [NUM_TILES-1:0]   sw_rdy,
  output logic [1:0]             sw_msg,
  output logic [NUM_TILES-1:0]   stall,
  output logic [2*NUM_TILES-1:0] cur_sel,
  output logic                   busy
);

  localparam int unsigned PTR_W   = $clog2(NUM_TILES);
  localparam int unsigned CNT_MAX = (QUIESCE_CYCLES > SETTLE_CYCLES) ? QUIESCE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [2*NUM_TILES-1:0] CUR_SEL_RST = {NUM_TILES{CLK_SEL_RESET}};

  sched_state_t           state_q, state_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [PTR_W-1:0]       tgt_q, tgt_d;
  clk_sel_t               msg_q, msg_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2*NUM_TILES-1:0] cur_sel_q, cur_sel_d;

  logic [NUM_TILES-1:0]   grant;
  logic [PTR_W-1:0]       win_idx;
  clk_sel_t               win_sel;
  logic                   switch_done;

  rr_arbiter #(
    .NUM_REQ (NUM_TILES),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req   (req_val),
    .ptr   (ptr_q),
    .grant (grant)
  );

  // Encode the one-hot grant and normalise the winner's requested select.
  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < NUM_TILES; i++) begin
      if (grant[i]) win_idx = PTR_W'(i);
    end
    win_sel = normalize_sel(req_msg[2*int'(win_idx) +: 2]);
  end

  // Next-state and output logic for the request/stall/switch sequence.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    tgt_d       = tgt_q;
    msg_d       = msg_q;
    cnt_d       = cnt_q;
    cur_sel_d   = cur_sel_q;
    req_rdy     = '0;
    sw_val      = '0;
    stall       = '0;
    switch_done = 1'b0;
    case (state_q)
      IDLE: begin
        req_rdy = grant;
        if (|grant) begin
          ptr_d = (win_idx == PTR_W'(NUM_TILES - 1)) ? '0 : win_idx + PTR_W'(1);
          // A request for the already-committed select completes here.
          if (win_sel != clk_sel_t'(cur_sel_q[2*int'(win_idx) +: 2])) begin
            tgt_d   = win_idx;
            msg_d   = win_sel;
            cnt_d   = CNT_W'(QUIESCE_CYCLES - 1);
            state_d = QUIESCE;
          end
        end
      end
      QUIESCE: begin
        stall[tgt_q] = 1'b1;
        if (cnt_q == '0) state_d = ISSUE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ISSUE: begin
        stall[tgt_q]  = 1'b1;
        sw_val[tgt_q] = 1'b1;
        if (sw_rdy[tgt_q]) begin
          cur_sel_d[2*int'(tgt_q) +: 2] = msg_q;
          cnt_d       = CNT_W'(SETTLE_CYCLES - 1);
          state_d     = SETTLE;
          switch_done = 1'b1;
        end
      end
      SETTLE: begin
        stall[tgt_q] = 1'b1;
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      tgt_q     <= '0;
      msg_q     <= CLK_SEL_RESET;
      cnt_q     <= '0;
      cur_sel_q <= CUR_SEL_RST;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      tgt_q     <= tgt_d;
      msg_q     <= msg_d;
      cnt_q     <= cnt_d;
      cur_sel_q <= cur_sel_d;
    end
  end

  assign sw_msg  = msg_q;
  assign cur_sel = cur_sel_q;
  assign busy    = (state_q != IDLE);

`ifdef CLK_SWITCH_SCHED_PERF_EN
  logic [15:0] switch_count_q, switch_count_d;

  // Count accepted switches, saturating at all-ones.
  always_comb begin
    switch_count_d = switch_count_q;
    if (switch_done && (switch_count_q != '1)) switch_count_d = switch_count_q + 16'd1;
  end

  // Switch counter register.
  always_ff @(posedge clk) begin
    if (reset) switch_count_q <= '0;
    else       switch_count_q <= switch_count_d;
  end

  assign switch_count = switch_count_q;
`endif

endmodule

// File: tb/tb_clk_switch_sched.sv
// Directed self-checking bench for clk_switch_sched (default parameters).
module tb_clk_switch_sched;
  localparam int unsigned N = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_val;
  logic [N-1:0]  req_rdy;
  logic [2*N-1:0] req_msg;
  logic [N-1:0]  sw_val;
  logic [N-1:0]  sw_rdy;
  logic [1:0]    sw_msg;
  logic [N-1:0]  stall;
  logic [2*N-1:0] cur_sel;
  logic          busy;
`ifdef CLK_SWITCH_SCHED_PERF_EN
  logic [15:0]   switch_count;
`endif

  int unsigned    n_checks = 0;
  int unsigned    n_fail   = 0;
  logic [2*N-1:0] exp_cur;

  clk_switch_sched #(
    .NUM_TILES      (N),
    .QUIESCE_CYCLES (2),
    .SETTLE_CYCLES  (4)
  ) dut (
`ifdef CLK_SWITCH_SCHED_PERF_EN
    .switch_count (switch_count),
`endif
    .clk     (clk),
    .reset   (reset),
    .req_val (req_val),
    .req_rdy (req_rdy),
    .req_msg (req_msg),
    .sw_val  (sw_val),
    .sw_rdy  (sw_rdy),
    .sw_msg  (sw_msg),
    .stall   (stall),
    .cur_sel (cur_sel),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    req_val = '0;
    tick();
    reset   = 1'b0;
    exp_cur = {N{2'b10}};
  endtask

  // Single real switch with sw_rdy all ones; cycle 0 is the accept cycle.
  task automatic do_switch(input int unsigned tile, input logic [1:0] msg, input logic [1:0] exp_sel);
    logic [N-1:0] oh;
    logic [1:0]   old_sel;
    oh      = N'(1) << tile;
    old_sel = exp_cur[2*tile +: 2];
    sw_rdy  = '1;
    req_val = oh;
    req_msg[2*tile +: 2] = msg;
    #1;
    check("acc_rdy", 64'(req_rdy), 64'(oh));
    tick();
    req_val = '0;
    for (int unsigned c = 1; c <= 8; c++) begin
      check("sw_stall", 64'(stall), (c <= 7) ? 64'(oh) : 64'd0);
      check("sw_val", 64'(sw_val), (c == 3) ? 64'(oh) : 64'd0);
      check("sw_busy", 64'(busy), (c <= 7) ? 64'd1 : 64'd0);
      if (c == 3) check("sw_msg", 64'(sw_msg), 64'(exp_sel));
      check("sw_cur", 64'(cur_sel[2*tile +: 2]), (c >= 4) ? 64'(exp_sel) : 64'(old_sel));
      if (c < 8) tick();
    end
    exp_cur[2*tile +: 2] = exp_sel;
    check("sw_cur_all", 64'(cur_sel), 64'(exp_cur));
  endtask

  // One-cycle no-op accept of a single tile.
  task automatic do_noop(input int unsigned tile, input logic [1:0] msg);
    req_val = N'(1) << tile;
    req_msg[2*tile +: 2] = msg;
    #1;
    check("noop_rdy", 64'(req_rdy), 64'(N'(1) << tile));
    tick();
    req_val = '0;
    #1;
    check("noop_busy", 64'(busy), 64'd0);
    check("noop_stall", 64'(stall), 64'd0);
    check("noop_val", 64'(sw_val), 64'd0);
    check("noop_cur", 64'(cur_sel), 64'(exp_cur));
  endtask

  initial begin
    req_val = '0;
    req_msg = '0;
    sw_rdy  = '1;
    reset   = 1'b1;
    tick();
    do_reset();

    // Reset values
    check("rst_rdy", 64'(req_rdy), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_val", 64'(sw_val), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_msg", 64'(sw_msg), 64'd2);
    check("rst_cur", 64'(cur_sel), 64'hAAAA_AAAA);

    // Tile 3 to fast
    do_switch(3, 2'b00, 2'b00);

    // Tile 5 no-op (already nominal); ptr becomes 6
    do_noop(5, 2'b10);
    req_val = (N'(1) << 4) | (N'(1) << 6);
    req_msg[9:8]   = 2'b10;
    req_msg[13:12] = 2'b10;
    #1;
    check("ptr6_grant", 64'(req_rdy), 64'(N'(1) << 6));
    tick();
    check("ptr7_grant", 64'(req_rdy), 64'(N'(1) << 4));
    tick();
    req_val = '0;

    // Round robin among 0, 1, 15 from ptr 0, continuous no-ops
    do_reset();
    req_msg = {N{2'b10}};
    req_val = (N'(1) << 0) | (N'(1) << 1) | (N'(1) << 15);
    begin
      int unsigned order [5] = '{0, 1, 15, 0, 1};
      for (int unsigned k = 0; k < 5; k++) begin
        #1;
        check("rr_grant", 64'(req_rdy), 64'(N'(1) << order[k]));
        check("rr_busy", 64'(busy), 64'd0);
        tick();
      end
    end
    req_val = '0;

    // Tile 2 to slow with sw_rdy[2] held low for 5 ISSUE cycles
    req_val = N'(1) << 2;
    req_msg[5:4] = 2'b01;
    sw_rdy  = ~(N'(1) << 2);
    #1;
    check("hold_rdy", 64'(req_rdy), 64'(N'(1) << 2));
    tick();
    req_val = '0;
    for (int unsigned c = 1; c <= 2; c++) begin
      check("hold_q_stall", 64'(stall), 64'(N'(1) << 2));
      check("hold_q_val", 64'(sw_val), 64'd0);
      tick();
    end
    for (int unsigned c = 3; c <= 7; c++) begin
      check("hold_i_val", 64'(sw_val), 64'(N'(1) << 2));
      check("hold_i_stall", 64'(stall), 64'(N'(1) << 2));
      check("hold_i_msg", 64'(sw_msg), 64'd1);
      check("hold_i_cur", 64'(cur_sel[5:4]), 64'd2);
      tick();
    end
    sw_rdy = '1;
    #1;
    check("hold_rise_val", 64'(sw_val), 64'(N'(1) << 2));
    tick();
    exp_cur[5:4] = 2'b01;
    for (int unsigned c = 9; c <= 12; c++) begin
      check("hold_s_val", 64'(sw_val), 64'd0);
      check("hold_s_stall", 64'(stall), 64'(N'(1) << 2));
      check("hold_s_cur", 64'(cur_sel), 64'(exp_cur));
      tick();
    end
    check("hold_done_busy", 64'(busy), 64'd0);
    check("hold_done_stall", 64'(stall), 64'd0);

    // Reset during SETTLE of tile 7
    req_val = N'(1) << 7;
    req_msg[15:14] = 2'b01;
    #1;
    check("rs_rdy", 64'(req_rdy), 64'(N'(1) << 7));
    tick();
    req_val = '0;
    tick(); tick(); tick();
    check("rs_cur7", 64'(cur_sel[15:14]), 64'd1);
    tick();
    check("rs_settle", 64'(stall), 64'(N'(1) << 7));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_cur = {N{2'b10}};
    check("rs_stall", 64'(stall), 64'd0);
    check("rs_busy", 64'(busy), 64'd0);
    check("rs_val", 64'(sw_val), 64'd0);
    check("rs_msg", 64'(sw_msg), 64'd2);
    check("rs_cur", 64'(cur_sel), 64'hAAAA_AAAA);

    // Encoding 11 behaves as nominal
    do_noop(4, 2'b11);
    do_switch(4, 2'b00, 2'b00);
    do_switch(4, 2'b11, 2'b10);
`ifdef CLK_SWITCH_SCHED_PERF_EN
    check("perf_count", 64'(switch_count), 64'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
